seq_stim_gen: RTL and testbench

//  Stimulus generator producing the three-signal pattern x ##D1 y[*N] ##D2 z on
//  one clock, i.e. the driver side of a delay/repetition sequence cover. Sits in

---
 rtl/seq_stim_gen.sv | 158 +++++++++++++++
 tb/tb_seq_stim_gen.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/seq_stim_gen.sv
// Driver for the x ##D1 y[*N] ##D2 z sequence pattern.
// One sequence per accepted start; completed sequences are counted.
module seq_stim_gen #(
   parameter int DW      = 4,
   parameter int RW      = 4,
   parameter int REP_MIN = 3,
   parameter int REP_MAX = 4,
   parameter int CW      = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] delay1,
   input  logic [DW-1:0] delay2,
   input  logic [RW-1:0] reps,
   output logic          x,
   output logic          y,
   output logic          z,
   output logic          busy,
   output logic          done,
   output logic          clamped,
   output logic [CW-1:0] seq_count
);

   localparam int CNTW = (DW > RW) ? DW : RW;

   typedef enum logic [2:0] {
      IDLE,
      ST_X,
      GAP1,
      ST_Y,
      GAP2,
      ST_Z
   } state_t;

   state_t          state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [DW-1:0]   d1_q, d2_q;
   logic [RW-1:0]   n_q;
   logic            clamped_q;
   logic [CW-1:0]   seq_cnt_q;

   logic [DW-1:0]   d1_c, d2_c;
   logic [RW-1:0]   n_c;
   logic            adj;
   logic            accept;

   assign accept = start && (state_q == IDLE);

   // Legalise the requested fields and flag any adjustment
   always_comb begin
      d1_c = delay1;
      d2_c = delay2;
      n_c  = reps;
      adj  = 1'b0;
      if (delay1 == '0) begin
         d1_c = DW'(1);
         adj  = 1'b1;
      end
      if (delay2 == '0) begin
         d2_c = DW'(1);
         adj  = 1'b1;
      end
      if (reps < RW'(REP_MIN)) begin
         n_c = RW'(REP_MIN);
         adj = 1'b1;
      end else if (reps > RW'(REP_MAX)) begin
         n_c = RW'(REP_MAX);
         adj = 1'b1;
      end
   end

   // State, phase counter, latched fields and completion count
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         d1_q      <= DW'(1);
         d2_q      <= DW'(1);
         n_q       <= RW'(REP_MIN);
         clamped_q <= 1'b0;
         seq_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         clamped_q <= accept && adj;
         if (accept) begin
            d1_q <= d1_c;
            d2_q <= d2_c;
            n_q  <= n_c;
         end
         if (state_q == ST_Z) begin
            seq_cnt_q <= seq_cnt_q + CW'(1);
         end
      end
   end

   // Phase sequencing; the counter is reloaded on entry to each timed phase
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q - CNTW'(1);
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = ST_X;
            end
         end
         ST_X: begin
            if (d1_q > DW'(1)) begin
               state_d = GAP1;
               cnt_d   = CNTW'(d1_q);
            end else begin
               state_d = ST_Y;
               cnt_d   = CNTW'(n_q);
            end
         end
         GAP1: begin
            if (cnt_q == CNTW'(2)) begin
               state_d = ST_Y;
               cnt_d   = CNTW'(n_q);
            end
         end
         ST_Y: begin
            if (cnt_q == CNTW'(1)) begin
               if (d2_q > DW'(1)) begin
                  state_d = GAP2;
                  cnt_d   = CNTW'(d2_q);
               end else begin
                  state_d = ST_Z;
               end
            end
         end
         GAP2: begin
            if (cnt_q == CNTW'(2)) begin
               state_d = ST_Z;
            end
         end
         ST_Z: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decoded straight from the current phase
   always_comb begin
      x         = (state_q == ST_X);
      y         = (state_q == ST_Y);
      z         = (state_q == ST_Z);
      done      = (state_q == ST_Z);
      busy      = (state_q != IDLE);
      clamped   = clamped_q;
      seq_count = seq_cnt_q;
   end

endmodule

// File: tb/tb_seq_stim_gen.sv
// Bench for seq_stim_gen: directed scenarios plus random traffic
// checked against a cycle-offset reference model.
module tb_seq_stim_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] delay1 = '0;
   logic [3:0] delay2 = '0;
   logic [3:0] reps = '0;
   logic       x, y, z, busy, done, clamped;
   logic [3:0] seq_count;

   int vecs = 0;
   int errs = 0;
   int cycle = 0;

   // reference model: m_t is cycles since accept (0 = idle)
   int m_t = 0;
   int m_d1 = 1;
   int m_n = 3;
   int m_d2 = 1;
   int m_L = 5;
   int m_cnt = 0;
   bit m_clp = 1'b0;

   always #5 clk = ~clk;

   seq_stim_gen #(
      .DW(4), .RW(4), .REP_MIN(3), .REP_MAX(4), .CW(4)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .delay1(delay1), .delay2(delay2), .reps(reps),
      .x(x), .y(y), .z(z), .busy(busy), .done(done),
      .clamped(clamped), .seq_count(seq_count)
   );

   task automatic chk(input string tag, input logic got, input logic exp);
      vecs++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cycle, got, exp);
      end
   endtask

   task automatic step(input bit s, input int a, input int b,
                       input int c, input bit r);
      rst    = r;
      start  = s;
      delay1 = 4'(a);
      reps   = 4'(b);
      delay2 = 4'(c);
      @(posedge clk);
      cycle++;
      m_clp = 1'b0;
      if (r) begin
         m_t   = 0;
         m_cnt = 0;
      end else if (m_t != 0 && m_t == m_L) begin
         m_t = 0;
         m_cnt++;
      end else if (m_t != 0) begin
         m_t++;
      end else if (s) begin
         m_d1  = (a == 0) ? 1 : a;
         m_d2  = (c == 0) ? 1 : c;
         m_n   = (b < 3) ? 3 : ((b > 4) ? 4 : b);
         m_clp = (a == 0) || (c == 0) || (b < 3) || (b > 4);
         m_L   = m_d1 + m_n + m_d2;
         m_t   = 1;
      end
      #1;
      chk("x", x, m_t == 1);
      chk("y", y, (m_t >= 1 + m_d1) && (m_t <= m_d1 + m_n));
      chk("z", z, (m_t != 0) && (m_t == m_L));
      chk("done", done, (m_t != 0) && (m_t == m_L));
      chk("busy", busy, m_t != 0);
      chk("clamped", clamped, m_clp);
      vecs++;
      assert (seq_count === 4'(m_cnt)) else begin
         errs++;
         $error("FAIL seq_count cyc=%0d got=%0d exp=%0d",
                cycle, seq_count, m_cnt % 16);
      end
   endtask

   initial begin
      // reset state
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);

      // basic timing d1=2 n=3 d2=1
      step(1, 2, 3, 1, 0);
      repeat (8) step(0, 0, 0, 0, 0);

      // all fields clamped
      step(1, 0, 9, 0, 0);
      repeat (7) step(0, 0, 0, 0, 0);

      // start held high: relaunch only after one idle cycle
      repeat (14) step(1, 1, 3, 1, 0);
      repeat (6) step(0, 0, 0, 0, 0);

      // reset while in the y phase
      step(0, 0, 0, 0, 1);
      step(1, 2, 4, 2, 0);
      repeat (3) step(0, 5, 5, 5, 0);
      step(0, 0, 0, 0, 1);
      repeat (2) step(0, 0, 0, 0, 0);
      step(1, 2, 3, 1, 0);
      repeat (8) step(1'b0, 7, 1, 9, 0);

      // counter wrap over 17 sequences
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 17; i++) begin
         step(1, $urandom_range(0, 3), $urandom_range(0, 6),
              $urandom_range(0, 3), 0);
         while (m_t != 0) step(0, 0, 0, 0, 0);
      end
      vecs++;
      assert (seq_count === 4'd1) else begin
         errs++;
         $error("FAIL wrap got=%0d exp=1", seq_count);
      end

      // longest legal sequence, no clamping
      step(1, 15, 4, 15, 0);
      repeat (36) step(0, 0, 0, 0, 0);

      // random traffic, fields change while busy
      repeat (600) begin
         step($urandom_range(0, 2) == 0,
              $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 149) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
